// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared packet bus: pops one packet from a granted
// source, routes it by destination ID (unicast or broadcast) and pushes it out.
module bus_arbiter #(
    parameter int          DRIVERS   = 4,
    parameter int          WIDTH     = 32,
    parameter logic [7:0]  BROADCAST = 8'hFF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DRIVERS-1:0]         pndng_i,
    input  logic [DRIVERS*WIDTH-1:0]   d_pop_i,
    input  logic [DRIVERS-1:0]         full_i,
    output logic [DRIVERS-1:0]         pop_o,
    output logic [DRIVERS-1:0]         push_o,
    output logic [WIDTH-1:0]           d_push_o,
    output logic [DRIVERS-1:0]         grant_o,
    output logic                       drop_o,
    output logic [15:0]                xfer_cnt_o
);

    localparam int IW = (DRIVERS > 1) ? $clog2(DRIVERS) : 1;
    localparam logic [7:0] DRV8 = 8'(DRIVERS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]         state_r;
    logic [IW-1:0]      gidx_r;
    logic [IW-1:0]      last_r;
    logic [WIDTH-1:0]   hold_r;

    logic [IW-1:0]      pick_s;
    logic               found_s;
    int                 cand_s;
    logic [DRIVERS-1:0] pick_oh_s;
    logic [7:0]         dest_s;
    logic [DRIVERS-1:0] mask_s;
    logic               drop_s;
    logic               blocked_s;

    // Round-robin search: first pending source after the last one served
    always_comb begin
        pick_s  = last_r;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 1; k <= DRIVERS; k++) begin
            cand_s = (int'(last_r) + k) % DRIVERS;
            if (!found_s && pndng_i[cand_s]) begin
                found_s = 1'b1;
                pick_s  = IW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
        pick_oh_s = {{(DRIVERS-1){1'b0}}, 1'b1} << pick_s;
    end

    // Route decode of the held packet; self-addressed or unknown IDs are discarded
    always_comb begin
        dest_s = hold_r[WIDTH-1 -: 8];
        mask_s = {DRIVERS{1'b0}};
        drop_s = 1'b0;
        if (dest_s == BROADCAST) begin
            mask_s         = {DRIVERS{1'b1}};
            mask_s[gidx_r] = 1'b0;
        end else if (dest_s < DRV8) begin
            if (dest_s == 8'(gidx_r)) begin
                drop_s = 1'b1;
            end else begin
                mask_s[dest_s[IW-1:0]] = 1'b1;
            end
        end else begin
            drop_s = 1'b1;
        end
        blocked_s = |(mask_s & full_i);
    end

    // Transaction FSM and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            gidx_r     <= {IW{1'b0}};
            last_r     <= IW'(DRIVERS - 1);
            hold_r     <= {WIDTH{1'b0}};
            pop_o      <= {DRIVERS{1'b0}};
            push_o     <= {DRIVERS{1'b0}};
            grant_o    <= {DRIVERS{1'b0}};
            drop_o     <= 1'b0;
            d_push_o   <= {WIDTH{1'b0}};
            xfer_cnt_o <= 16'd0;
        end else begin
            pop_o  <= {DRIVERS{1'b0}};
            push_o <= {DRIVERS{1'b0}};
            drop_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        gidx_r  <= pick_s;
                        grant_o <= pick_oh_s;
                        pop_o   <= pick_oh_s;
                        state_r <= ST_POP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_POP: begin
                    hold_r  <= d_pop_i[int'(gidx_r)*WIDTH +: WIDTH];
                    state_r <= ST_PUSH;
                end
                ST_PUSH, ST_WAIT: begin
                    if (drop_s) begin
                        drop_o  <= 1'b1;
                        last_r  <= gidx_r;
                        grant_o <= {DRIVERS{1'b0}};
                        state_r <= ST_IDLE;
                    end else if (blocked_s) begin
                        state_r <= ST_WAIT;
                    end else begin
                        push_o     <= mask_s;
                        d_push_o   <= hold_r;
                        xfer_cnt_o <= xfer_cnt_o + 16'd1;
                        last_r     <= gidx_r;
                        grant_o    <= {DRIVERS{1'b0}};
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed packets feed modelled source FIFOs,
// expected grants/pushes/drops are queued and a negedge monitor compares them.
module tb_bus_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   pndng_i, full_i, pop_o, push_o, grant_o;
    logic [N*W-1:0] d_pop_i;
    logic [W-1:0]   d_push_o;
    logic           drop_o;
    logic [15:0]    xfer_cnt_o;

    bus_arbiter #(.DRIVERS(N), .WIDTH(W), .BROADCAST(8'hFF)) dut (
        .clk_i(clk), .rst_i(rst), .pndng_i(pndng_i), .d_pop_i(d_pop_i),
        .full_i(full_i), .pop_o(pop_o), .push_o(push_o), .d_push_o(d_push_o),
        .grant_o(grant_o), .drop_o(drop_o), .xfer_cnt_o(xfer_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_drop;
        logic [N-1:0] mask;
        logic [W-1:0] data;
        logic [15:0]  cnt;
    } evt_t;

    evt_t   exp_evt[$];
    int     exp_grant[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     exp_cnt = 0;
    int     last_pop_cyc = -1;
    int     last_push_cyc = -1;
    bit     rr_mode = 1'b0;

    logic [W-1:0] words [N][8];
    int head [N];
    int tail [N];

    always @(posedge clk) cyc <= cyc + 1;

    // Source FIFO model: head advances on the DUT pop strobe
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < N; i++) begin
            if (rst) head[i] <= 0;
            else if (pop_o[i]) head[i] <= head[i] + 1;
        end
    end

    always_comb begin
        pndng_i = '0;
        d_pop_i = '0;
        for (int i = 0; i < N; i++) begin
            pndng_i[i] = (head[i] != tail[i]);
            if (head[i] < tail[i] && head[i] < 8) d_pop_i[i*W +: W] = words[i][head[i]];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic enq(input int t, input logic [W-1:0] w);
        words[t][tail[t]] = w;
        tail[t] = tail[t] + 1;
    endtask

    task automatic exp_push(input int g, input logic [N-1:0] m, input logic [W-1:0] d);
        evt_t e;
        exp_cnt++;
        e.is_drop = 1'b0; e.mask = m; e.data = d; e.cnt = 16'(exp_cnt);
        exp_grant.push_back(g);
        exp_evt.push_back(e);
    endtask

    task automatic exp_drop(input int g);
        evt_t e;
        e.is_drop = 1'b1; e.mask = '0; e.data = '0; e.cnt = 16'(exp_cnt);
        exp_grant.push_back(g);
        exp_evt.push_back(e);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        full_i = '0;
        for (int i = 0; i < N; i++) tail[i] = 0;
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_done;
        int k;
        k = 0;
        while ((exp_grant.size() != 0 || exp_evt.size() != 0 || grant_o != '0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("timeout_idle", 64'(k >= 200), 64'd0);
        @(negedge clk);
    endtask

    // Monitor: compares every pop, push and drop against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            if (pop_o != '0) begin
                if (exp_grant.size() == 0) begin
                    chk("unexpected_pop", 64'(pop_o), 64'd0);
                end else begin
                    int g;
                    g = exp_grant.pop_front();
                    chk("pop_onehot", 64'(pop_o), 64'd1 << g);
                    chk("grant_onehot", 64'(grant_o), 64'd1 << g);
                    if (rr_mode && last_pop_cyc >= 0) chk("rr_spacing", 64'(cyc - last_pop_cyc), 64'd3);
                    last_pop_cyc = cyc;
                end
            end
            if (push_o != '0 || drop_o) begin
                if (exp_evt.size() == 0) begin
                    chk("unexpected_push_drop", 64'({push_o, drop_o}), 64'd0);
                end else begin
                    evt_t e;
                    e = exp_evt.pop_front();
                    chk("evt_is_drop", 64'(drop_o), 64'(e.is_drop));
                    chk("push_mask", 64'(push_o), 64'(e.mask));
                    chk("xfer_cnt", 64'(xfer_cnt_o), 64'(e.cnt));
                    if (!e.is_drop) chk("push_data", 64'(d_push_o), 64'(e.data));
                    if (push_o != '0) last_push_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        rst = 1'b1;
        full_i = '0;
        for (int i = 0; i < N; i++) tail[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 64'({pop_o, push_o, grant_o, drop_o}), 64'd0);
        chk("rst_cnt_data", 64'({xfer_cnt_o, d_push_o}), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Unicast from terminal 1 to terminal 3
        enq(1, 32'h0300_0002);
        exp_push(1, 4'b1000, 32'h0300_0002);
        wait_done();
        chk("hold_d_push_idle", 64'(d_push_o), 64'h0300_0002);

        // Round-robin from reset with every source pending
        do_reset();
        rr_mode = 1'b1;
        last_pop_cyc = -1;
        enq(0, 32'h0100_0010); enq(0, 32'h0200_0014);
        enq(1, 32'h0200_0011); enq(2, 32'h0300_0012); enq(3, 32'h0000_0013);
        exp_push(0, 4'b0010, 32'h0100_0010);
        exp_push(1, 4'b0100, 32'h0200_0011);
        exp_push(2, 4'b1000, 32'h0300_0012);
        exp_push(3, 4'b0001, 32'h0000_0013);
        exp_push(0, 4'b0100, 32'h0200_0014);
        wait_done();
        rr_mode = 1'b0;

        // Broadcast from terminal 2
        enq(2, 32'hFF00_0005);
        exp_push(2, 4'b1011, 32'hFF00_0005);
        wait_done();

        // Backpressure on terminal 3 during a unicast from terminal 1
        full_i[3] = 1'b1;
        enq(1, 32'h0300_0009);
        exp_push(1, 4'b1000, 32'h0300_0009);
        rel = 0;
        while (grant_o == '0 && rel < 20) begin
            @(negedge clk);
            rel++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_grant_held", 64'(grant_o), 64'b0010);
            chk("bp_no_push", 64'(push_o), 64'd0);
        end
        full_i[3] = 1'b0;
        rel = cyc;
        wait_done();
        chk("bp_push_cycle", 64'(last_push_cyc), 64'(rel + 1));

        // Self-addressed drop from terminal 2, then terminal 3 is served
        enq(2, 32'h0200_0020);
        enq(3, 32'h0000_0021);
        exp_drop(2);
        exp_push(3, 4'b0001, 32'h0000_0021);
        wait_done();

        // Out-of-range ID drop from terminal 0
        enq(0, 32'h0700_0030);
        exp_drop(0);
        wait_done();
        chk("cnt_after_drop", 64'(xfer_cnt_o), 64'(exp_cnt));

        // Reset while waiting on a full receiver
        full_i[0] = 1'b1;
        enq(1, 32'h0000_0040);
        exp_grant.push_back(1);
        repeat (6) @(negedge clk);
        chk("pre_rst_grant", 64'(grant_o), 64'b0010);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", 64'({pop_o, push_o, grant_o, drop_o}), 64'd0);
        chk("midrst_cnt_data", 64'({xfer_cnt_o, d_push_o}), 64'd0);
        do_reset();
        enq(0, 32'h0200_0050);
        enq(2, 32'h0100_0052);
        exp_push(0, 4'b0100, 32'h0200_0050);
        exp_push(2, 4'b0010, 32'h0100_0052);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter DRIVERS, default 4, meaning the number of terminals sharing the bus (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 32, meaning the packet width in bits; bits [WIDTH-1:WIDTH-8] hold the destination ID.
REQ-003 The block SHALL have parameter BROADCAST, default 8'hFF, meaning the destination ID that addresses all terminals.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port pndng_i, input, DRIVERS bits: bit i high means terminal i's source FIFO is non-empty.
REQ-007 The block SHALL have port d_pop_i, input, DRIVERS*WIDTH bits: the head word of each source FIFO, slice i belongs to terminal i.
REQ-008 The block SHALL have port full_i, input, DRIVERS bits: bit i high means terminal i's receive FIFO cannot accept a push.
REQ-009 The block SHALL have port pop_o, output, DRIVERS bits: a one-cycle pop strobe to the granted source.
REQ-010 The block SHALL have port push_o, output, DRIVERS bits: a one-cycle push strobe to each destination.
REQ-011 The block SHALL have port d_push_o, output, WIDTH bits: the packet driven to all receivers.
REQ-012 The block SHALL have port grant_o, output, DRIVERS bits: the one-hot current owner of the bus, all-zero when idle.
REQ-013 The block SHALL have port drop_o, output, 1 bit: a one-cycle pulse when a packet is discarded.
REQ-014 The block SHALL have port xfer_cnt_o, output, 16 bits: the number of completed transfers, wrapping from 16'hFFFF to 0.

Function
REQ-015 The FSM SHALL have states IDLE, POP, PUSH and WAIT.
- Encoding is free.
- Exactly one state is active.
REQ-016 In IDLE with any pndng_i bit set, the block SHALL grant round-robin starting at (last_grant+1) mod DRIVERS.
- grant_o is registered.
- Next state is POP.
REQ-017 In POP, the block SHALL do the following for exactly one cycle:
- assert pop_o[g];
- capture slice g of d_pop_i into the hold register;
- go to PUSH.
REQ-018 In PUSH, destination ID = hold[WIDTH-1:WIDTH-8]; the target mask SHALL be:
- one-hot at the ID when ID < DRIVERS;
- all bits except g when ID == BROADCAST.
REQ-019 In PUSH, if ID >= DRIVERS and ID != BROADCAST, or ID == g, the block SHALL discard the packet:
- pulse drop_o;
- assert no push;
- go to IDLE.
REQ-020 In PUSH or WAIT, when no target has full_i set, the block SHALL do the following for exactly one cycle:
- drive d_push_o = hold;
- assert push_o = mask;
- increment xfer_cnt_o;
- set last_grant = g;
- go to IDLE.
REQ-021 In PUSH or WAIT, if any target has full_i set, the block SHALL hold push_o = 0 and stay in or enter WAIT.
- The hold register and grant are kept.
- A broadcast waits until all targets are ready, so delivery is all-or-nothing.
REQ-022 The block SHALL assert grant_o through POP, PUSH and WAIT.
- grant_o clears on entry to IDLE.
- The minimum spacing is 3 cycles per packet.
REQ-023 A dropped packet SHALL also update last_grant = g so that arbitration stays fair.
REQ-024 Changes of pndng_i after the grant SHALL NOT change the current transaction.
REQ-025 d_push_o SHALL hold its last value outside PUSH/WAIT; receivers sample it only with push_o.
REQ-026 A source whose pndng_i drops while a transfer is in progress SHALL simply not be selected next time.

Reset
REQ-027 On asserting rst_i, the block SHALL immediately, regardless of clk_i:
- set state = IDLE;
- set pop_o = push_o = grant_o = 0, drop_o = 0, d_push_o = 0 and xfer_cnt_o = 0;
- set last_grant = DRIVERS-1, so terminal 0 has priority first.
REQ-028 A reset during POP, PUSH or WAIT SHALL abandon the held packet without pushing it.
- If pop already happened, the packet is lost; this is accepted behaviour.
REQ-029 After rst_i deasserts, the first grant SHALL be issued no earlier than the first clock edge.

Verification
REQ-030 Unicast: pndng_i=4'b0010, d_pop slice1=32'h0300_0002 -> pop_o=4'b0010 then push_o=4'b1000, d_push_o=32'h0300_0002, xfer_cnt_o=1.
REQ-031 Round-robin: pndng_i=4'b1111 held high, all packets valid -> grants in order 0,1,2,3,0, with 3 cycles between grants.
REQ-032 Broadcast: terminal 2 sends 32'hFF00_0005 -> a single push with push_o=4'b1011.
REQ-033 Backpressure: full_i[3]=1 for 5 cycles during a unicast to 3 -> WAIT, push_o=0, then a single push on the cycle after full_i[3] falls.
REQ-034 Drop: ID=8'h07 with DRIVERS=4, or ID equal to the source -> drop_o pulses once, push_o stays 0, the counter is unchanged, and the next grant goes to the next terminal.
REQ-035 Mid-op reset: rst_i asserted in WAIT -> all outputs 0 within the same cycle; after release, terminal 0 is granted first.
